// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - UART receive frame sequencer with holding register and VALID/READY output
//
// Validates the start bit, strobes an external shift register at mid-bit for
// each data bit, samples the stop bit and captures the shift register into a
// holding register presented to the host over VALID/READY.
//
// Optional build macro: RX_PARITY_EN adds an even-parity bit between the data
// and stop bits and a PERR status output.
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   synchronous active-high reset
//   TICK     in   oversampling strobe, OSR per bit period
//   RXD_F    in   filtered serial line, idle high
//   SR_DATA  in   parallel contents of the external shift register
//   SHIFT_EN out  one-cycle strobe: shift RXD_F into the shift register
//   BUSY     out  frame in progress (state != IDLE)
//   DOUT     out  holding register
//   VALID    out  holding register full
//   READY    in   host accepts DOUT when VALID & READY
//   FERR     out  stop bit was low for the frame in DOUT
//   OVR      out  sticky overrun flag
//   CLR_ERR  in   clears OVR
//   PERR     out  parity error for the frame in DOUT (RX_PARITY_EN only)

module rx_frame_ctrl #(
    parameter int SIZE = 8,
    parameter int OSR  = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            TICK,
    input  logic            RXD_F,
    input  logic [SIZE-1:0] SR_DATA,
    output logic            SHIFT_EN,
    output logic            BUSY,
    output logic [SIZE-1:0] DOUT,
    output logic            VALID,
    input  logic            READY,
    output logic            FERR,
    output logic            OVR,
    input  logic            CLR_ERR
`ifdef RX_PARITY_EN
    ,
    output logic            PERR
`endif
);

    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(SIZE + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(OSR - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OSR / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [BW-1:0] bit_idx, bit_idx_nxt;
    logic          shift_en_c;
    logic          load_c;
    logic          accept;

`ifdef RX_PARITY_EN
    logic          par_sample_c;
    logic          par_acc;
    logic          par_err;
`endif

    assign cnt_inc = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_en_c  = 1'b0;
        load_c      = 1'b0;
`ifdef RX_PARITY_EN
        par_sample_c = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (TICK && !RXD_F) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (TICK) begin
                    if (cnt == CNT_HALF) begin
                        // Line back high at mid start bit: treat as a glitch.
                        cnt_nxt = '0;
                        if (RXD_F) begin
                            state_nxt = S_IDLE;
                        end else begin
                            bit_idx_nxt = '0;
                            state_nxt   = S_DATA;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            S_DATA: begin
                if (TICK) begin
                    cnt_nxt = cnt_inc;
                    if (cnt == CNT_MAX) begin
                        shift_en_c  = 1'b1;
                        bit_idx_nxt = bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef RX_PARITY_EN
                            state_nxt = S_PARITY;
`else
                            state_nxt = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (TICK) begin
                    cnt_nxt = cnt_inc;
                    if (cnt == CNT_MAX) begin
                        par_sample_c = 1'b1;
                        state_nxt    = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (TICK) begin
                    cnt_nxt = cnt_inc;
                    if (cnt == CNT_MAX) begin
                        load_c    = 1'b1;
                        state_nxt = RXD_F ? S_IDLE : S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Break or framing error: wait for the line to recover
                // so a held-low line is not mistaken for a new start bit.
                if (RXD_F) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Gated with RST so an aborted frame never shifts.
    assign SHIFT_EN = shift_en_c & ~RST;
    assign BUSY     = (state != S_IDLE);

    // A handshake in the load cycle frees the holding register for the new frame.
    assign accept = load_c && (!VALID || READY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT  <= '0;
            VALID <= 1'b0;
            FERR  <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            if (accept) begin
                DOUT  <= SR_DATA;
                FERR  <= ~RXD_F;
                VALID <= 1'b1;
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
            // Set has priority over clear.
            if (load_c && VALID && !READY) begin
                OVR <= 1'b1;
            end else if (CLR_ERR) begin
                OVR <= 1'b0;
            end
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_acc <= 1'b0;
            par_err <= 1'b0;
            PERR    <= 1'b0;
        end else begin
            if (state == S_START) begin
                par_acc <= 1'b0;
            end else if (shift_en_c) begin
                par_acc <= par_acc ^ RXD_F;
            end
            if (par_sample_c) begin
                // Even parity: data bits plus parity bit must XOR to zero.
                par_err <= par_acc ^ RXD_F;
            end
            if (accept) begin
                PERR <= par_err;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl

module tb_rx_frame_ctrl;

    localparam int SIZE = 8;
    localparam int OSR  = 16;

    logic            CLK     = 1'b0;
    logic            RST     = 1'b1;
    logic            TICK    = 1'b0;
    logic            RXD_F   = 1'b1;
    logic            READY   = 1'b0;
    logic            CLR_ERR = 1'b0;
    logic [SIZE-1:0] SR_DATA;
    logic            SHIFT_EN;
    logic            BUSY;
    logic [SIZE-1:0] DOUT;
    logic            VALID;
    logic            FERR;
    logic            OVR;

    logic [SIZE-1:0] sr = '0;

    int n_ticks       = 0;
    int cur_tick      = -1;
    int prev_tick_idx = -1;
    logic valid_d     = 1'b0;
    int valid_hi_cnt  = 0;
    int shift_q[$];
    int rise_q[$];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic            exp_valid = 1'b0;
    logic            exp_ferr  = 1'b0;
    logic            exp_ovr   = 1'b0;
    logic [SIZE-1:0] exp_dout  = '0;

    rx_frame_ctrl #(.SIZE(SIZE), .OSR(OSR)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TICK     (TICK),
        .RXD_F    (RXD_F),
        .SR_DATA  (SR_DATA),
        .SHIFT_EN (SHIFT_EN),
        .BUSY     (BUSY),
        .DOUT     (DOUT),
        .VALID    (VALID),
        .READY    (READY),
        .FERR     (FERR),
        .OVR      (OVR),
        .CLR_ERR  (CLR_ERR)
    );

    always #5 CLK = ~CLK;

    // External LSB-first shift register driven by SHIFT_EN.
    assign SR_DATA = sr;
    always @(posedge CLK) begin
        if (SHIFT_EN) sr <= {RXD_F, sr[SIZE-1:1]};
    end

    always @(negedge CLK) begin
        if (SHIFT_EN) shift_q.push_back(TICK ? cur_tick : -1);
        if (VALID && !valid_d) rise_q.push_back(prev_tick_idx);
        if (VALID) valid_hi_cnt <= valid_hi_cnt + 1;
        valid_d       <= VALID;
        prev_tick_idx <= TICK ? cur_tick : -1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic one_tick(input logic line, input bit rdy);
        @(posedge CLK); #1;
        TICK = 1'b1; RXD_F = line; cur_tick = n_ticks;
        if (rdy) READY = 1'b1;
        @(posedge CLK); #1;
        TICK = 1'b0;
        if (rdy) READY = 1'b0;
        n_ticks++;
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) one_tick(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [SIZE-1:0] d, input logic stop, input bit rdy_at_load,
                              output int t0);
        logic v;
        t0 = n_ticks;
        for (int b = 0; b < SIZE + 2; b++) begin
            v = (b == 0) ? 1'b0 : (b == SIZE + 1) ? stop : d[b-1];
            for (int k = 0; k < OSR; k++) one_tick(v, rdy_at_load && (b == SIZE + 1) && (k == OSR / 2));
        end
    endtask

    // Reference: stop sample lands mid stop bit; load rules applied at frame level.
    task automatic model_stop(input logic [SIZE-1:0] d, input logic stop, input bit rdy);
        if (!exp_valid || rdy) begin
            exp_valid = 1'b1; exp_dout = d; exp_ferr = ~stop;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic check_shifts(input string tag, input int base, input int t0, input int n);
        int v;
        check({tag, "_nshift"}, shift_q.size() - base, n);
        for (int k = 0; k < n; k++) begin
            v = (base + k < shift_q.size()) ? shift_q[base + k] : -2;
            check({tag, "_shift_tick"}, v, t0 + OSR + OSR / 2 + OSR * k);
        end
    endtask

    task automatic check_rise(input string tag, input int base, input int t0, input bit expect_rise);
        int v;
        if (expect_rise) begin
            check({tag, "_nrise"}, rise_q.size() - base, 1);
            v = (base < rise_q.size()) ? rise_q[base] : -2;
            check({tag, "_rise_tick"}, v, t0 + OSR * (SIZE + 1) + OSR / 2);
        end else begin
            check({tag, "_nrise"}, rise_q.size() - base, 0);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, VALID, exp_valid);
        check({tag, "_dout"}, DOUT, exp_dout);
        check({tag, "_ferr"}, FERR, exp_ferr);
        check({tag, "_ovr"}, OVR, exp_ovr);
    endtask

    task automatic consume();
        @(posedge CLK); #1; READY = 1'b1;
        @(posedge CLK); #1; READY = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic clear_err();
        @(posedge CLK); #1; CLR_ERR = 1'b1;
        @(posedge CLK); #1; CLR_ERR = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        int t0, sb, rb, vb;
        logic [SIZE-1:0] d;
        logic stop;
        bit exp_rise;

        // Reset state
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_shift_en", SHIFT_EN, 0);
        check_state("rst");
        @(posedge CLK); #1; RST = 1'b0;
        idle_ticks(4);

        // 0xA5 with READY high: one-cycle VALID pulse, shift timing
        READY = 1'b1;
        sb = shift_q.size(); rb = rise_q.size(); vb = valid_hi_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, t0);
        idle_ticks(2);
        check_shifts("a5", sb, t0, SIZE);
        check_rise("a5", rb, t0, 1'b1);
        check("a5_valid_cycles", valid_hi_cnt - vb, 1);
        check("a5_valid", VALID, 0);
        check("a5_dout", DOUT, 8'hA5);
        check("a5_ferr", FERR, 0);
        READY = 1'b0;
        exp_dout = 8'hA5; exp_ferr = 1'b0; exp_valid = 1'b0;

        // Start-bit glitch of 4 ticks
        sb = shift_q.size(); rb = rise_q.size();
        for (int i = 0; i < 4; i++) one_tick(1'b0, 1'b0);
        check("glitch_busy_start", BUSY, 1);
        idle_ticks(12);
        check("glitch_busy_idle", BUSY, 0);
        check("glitch_nshift", shift_q.size() - sb, 0);
        check("glitch_nrise", rise_q.size() - rb, 0);
        check_state("glitch");

        // 0x3C with low stop bit, line held low three bit times
        sb = shift_q.size(); rb = rise_q.size();
        send_frame(8'h3C, 1'b0, 1'b0, t0);
        model_stop(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3 * OSR; i++) one_tick(1'b0, 1'b0);
        check("brk_busy_wait", BUSY, 1);
        check_shifts("brk", sb, t0, SIZE);
        check_rise("brk", rb, t0, 1'b1);
        check_state("brk");
        one_tick(1'b1, 1'b0);
        check("brk_busy_release", BUSY, 0);
        idle_ticks(3);
        consume();
        check_state("brk_consumed");

        // Overrun: 0x11 then 0x22 with READY low
        send_frame(8'h11, 1'b1, 1'b0, t0);
        model_stop(8'h11, 1'b1, 1'b0);
        idle_ticks(2);
        check_state("ovr_first");
        rb = rise_q.size();
        send_frame(8'h22, 1'b1, 1'b0, t0);
        model_stop(8'h22, 1'b1, 1'b0);
        idle_ticks(2);
        check_rise("ovr_second", rb, t0, 1'b0);
        check_state("ovr_second");
        clear_err();
        check_state("ovr_clr");
        consume();
        check_state("ovr_consumed");

        // READY exactly on the load cycle while 0x66 pending
        send_frame(8'h66, 1'b1, 1'b0, t0);
        model_stop(8'h66, 1'b1, 1'b0);
        idle_ticks(2);
        check_state("hs_pending");
        rb = rise_q.size();
        send_frame(8'h77, 1'b1, 1'b1, t0);
        model_stop(8'h77, 1'b1, 1'b1);
        idle_ticks(2);
        check_rise("hs_load", rb, t0, 1'b0);
        check_state("hs_load");
        consume();
        check_state("hs_consumed");

        // Reset during data bit 4, then 0x5A
        sb = shift_q.size(); rb = rise_q.size();
        d = 8'h96;
        for (int k = 0; k < OSR; k++) one_tick(1'b0, 1'b0);
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < OSR; k++) one_tick(d[b], 1'b0);
        for (int k = 0; k < 5; k++) one_tick(d[4], 1'b0);
        @(posedge CLK); #1; RST = 1'b1; RXD_F = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        exp_valid = 1'b0; exp_dout = '0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_nshift", shift_q.size() - sb, 4);
        check_state("rst_mid");
        idle_ticks(6);
        check("rst_mid_nrise", rise_q.size() - rb, 0);
        sb = shift_q.size(); rb = rise_q.size();
        send_frame(8'h5A, 1'b1, 1'b0, t0);
        model_stop(8'h5A, 1'b1, 1'b0);
        idle_ticks(2);
        check_shifts("after_rst", sb, t0, SIZE);
        check_rise("after_rst", rb, t0, 1'b1);
        check_state("after_rst");

        // Randomized frames against the frame-level model
        for (int n = 0; n < 10; n++) begin
            d    = SIZE'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            sb = shift_q.size(); rb = rise_q.size();
            exp_rise = !exp_valid;
            send_frame(d, stop, 1'b0, t0);
            model_stop(d, stop, 1'b0);
            if (!stop) begin
                for (int i = 0; i < OSR * $urandom_range(1, 2); i++) one_tick(1'b0, 1'b0);
                check("rnd_busy_wait", BUSY, 1);
                one_tick(1'b1, 1'b0);
                check("rnd_busy_release", BUSY, 0);
            end
            idle_ticks($urandom_range(1, 4));
            check_shifts("rnd", sb, t0, SIZE);
            check_rise("rnd", rb, t0, exp_rise);
            check_state("rnd");
            if ($urandom_range(0, 1) == 1) begin
                consume();
                check_state("rnd_consume");
            end
            if ($urandom_range(0, 2) == 0) begin
                clear_err();
                check_state("rnd_clr");
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
